// File: rtl/axil_reg_scrub.sv
// rtl/axil_reg_scrub.sv - AXI4-Lite register scrubber: writes pattern+index to each register, optional readback verify
// Optional readback pass is enabled by defining AXIL_SCRUB_READBACK_EN.
module axil_reg_scrub #(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 4,
  parameter int  NUM_REGS   = 4,
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [IDX_W-1:0]      err_idx,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_W-1:0]     m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, FINISH
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] pattern_q, wdata_q;
  logic [IDX_W-1:0]      idx_q, err_idx_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic                  awvalid_q, wvalid_q, bready_q, busy_q, done_q, err_q;

  logic [IDX_W-1:0]      idx_d;
  logic                  last_idx, aw_done, w_done, b_fail;

  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [IDX_W-1:0] i);
    return ADDR_WIDTH'({i, 2'b00});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] reg_val(input logic [DATA_WIDTH-1:0] base,
                                                    input logic [IDX_W-1:0] i);
    return base + DATA_WIDTH'(i);
  endfunction

  assign idx_d    = idx_q + IDX_W'(1);
  assign last_idx = (idx_q == IDX_W'(NUM_REGS - 1));
  // A channel counts as done once its valid has already dropped or it handshakes now.
  assign aw_done  = !awvalid_q || m_axil_awready;
  assign w_done   = !wvalid_q || m_axil_wready;
  assign b_fail   = (m_axil_bresp != 2'b00);

`ifdef AXIL_SCRUB_READBACK_EN
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic                  arvalid_q, rready_q, r_fail;

  assign r_fail = (m_axil_rresp != 2'b00) || (m_axil_rdata != reg_val(pattern_q, idx_q));
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      err_idx_q <= '0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef AXIL_SCRUB_READBACK_EN
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pattern_q <= pattern;
            idx_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            busy_q    <= 1'b1;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= reg_addr('0);
            wdata_q   <= pattern;
            state_q   <= WR_ADDR_DATA;
          end
        end
        WR_ADDR_DATA: begin
          if (m_axil_awready) awvalid_q <= 1'b0;
          if (m_axil_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axil_bvalid) begin
            bready_q <= 1'b0;
            if (b_fail) begin
              err_q <= 1'b1;
              if (!err_q) err_idx_q <= idx_q;
            end
            if (!last_idx) begin
              idx_q     <= idx_d;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              awaddr_q  <= reg_addr(idx_d);
              wdata_q   <= reg_val(pattern_q, idx_d);
              state_q   <= WR_ADDR_DATA;
            end else begin
`ifdef AXIL_SCRUB_READBACK_EN
              idx_q     <= '0;
              arvalid_q <= 1'b1;
              araddr_q  <= reg_addr('0);
              state_q   <= RD_ADDR;
`else
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= FINISH;
`endif
            end
          end
        end
`ifdef AXIL_SCRUB_READBACK_EN
        RD_ADDR: begin
          if (m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axil_rvalid) begin
            rready_q <= 1'b0;
            if (r_fail) begin
              err_q <= 1'b1;
              if (!err_q) err_idx_q <= idx_q;
            end
            if (!last_idx) begin
              idx_q     <= idx_d;
              arvalid_q <= 1'b1;
              araddr_q  <= reg_addr(idx_d);
              state_q   <= RD_ADDR;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
`endif
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign err_idx        = err_idx_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_arprot  = 3'b000;

`ifdef AXIL_SCRUB_READBACK_EN
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
`else
  assign m_axil_araddr  = '0;
  assign m_axil_arvalid = 1'b0;
  assign m_axil_rready  = 1'b0;

  wire unused_rd = &{1'b0, m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid};
`endif

endmodule

// File: tb/tb_axil_reg_scrub.sv
// tb/tb_axil_reg_scrub.sv - scoreboard bench for axil_reg_scrub against a 4-register AXI4-Lite slave model
// Follows AXIL_SCRUB_READBACK_EN the same way as the design.
module tb_axil_reg_scrub;

`ifdef AXIL_SCRUB_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        aclk, areset, start;
  logic [31:0] pattern;
  logic        busy, done, err;
  logic [1:0]  err_idx;
  logic [3:0]  m_axil_awaddr, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [31:0] m_axil_wdata, m_axil_rdata;
  logic [3:0]  m_axil_wstrb;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;

  axil_reg_scrub dut (
    .aclk(aclk), .areset(areset), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  typedef struct packed { logic [3:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic e; logic [1:0] idx; } res_t;

  wr_t         exp_wr[$];
  logic [3:0]  exp_rd[$];
  res_t        exp_res[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, last_b_cyc = 0, last_r_cyc = 0;
  int          aw_delay, w_delay, bad_b, bad_r, corrupt_reg;
  int          wr_num = 0, rd_num = 0, dup_cnt = 0;
  logic [31:0] mem [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Slave model: decides ready/valid at the falling edge, so every handshake that
  // will happen at the next rising edge is already known here.
  initial begin
    bit         aw_got, w_got, ar_got, b_hs, r_hs;
    int         aw_wait, w_wait, ridx;
    logic [3:0] aw_a, ar_a;
    logic [31:0] w_d;
    wr_t        e;
    aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0; aw_wait = 0; w_wait = 0;
    aw_a = '0; ar_a = '0; w_d = '0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
    m_axil_bvalid = 0; m_axil_bresp = 0; m_axil_rvalid = 0; m_axil_rresp = 0; m_axil_rdata = 0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    forever begin
      @(negedge aclk);
      #1;
      if (areset) begin
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_bresp = 0; m_axil_rvalid = 0; m_axil_rresp = 0; m_axil_rdata = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0; aw_wait = 0; w_wait = 0;
      end else begin
        if (b_hs) begin m_axil_bvalid = 0; b_hs = 0; end
        if (aw_got && w_got && !m_axil_bvalid) begin
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %h data %h, none expected", aw_a, w_d);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", {28'h0, aw_a}, {28'h0, e.addr});
            chk("wr_data", w_d, e.data);
          end
          mem[aw_a[3:2]] = w_d;
          m_axil_bresp  = (wr_num == bad_b) ? 2'b10 : 2'b00;
          wr_num++;
          m_axil_bvalid = 1;
        end
        if (m_axil_bvalid && m_axil_bready) begin
          b_hs = 1; aw_got = 0; w_got = 0; last_b_cyc = cyc;
        end
        m_axil_awready = 0;
        if (m_axil_awvalid) begin
          if (aw_got) dup_cnt++;
          else if (aw_wait >= aw_delay) begin
            m_axil_awready = 1; aw_got = 1; aw_a = m_axil_awaddr; aw_wait = 0;
            chk("awprot", {29'h0, m_axil_awprot}, 32'h0);
          end else aw_wait++;
        end
        m_axil_wready = 0;
        if (m_axil_wvalid) begin
          if (w_got) dup_cnt++;
          else if (w_wait >= w_delay) begin
            m_axil_wready = 1; w_got = 1; w_d = m_axil_wdata; w_wait = 0;
            chk("wstrb", {28'h0, m_axil_wstrb}, 32'hf);
          end else w_wait++;
        end
        if (r_hs) begin m_axil_rvalid = 0; r_hs = 0; end
        if (ar_got && !m_axil_rvalid) begin
          ridx = int'(ar_a[3:2]);
          m_axil_rdata  = (ridx == corrupt_reg) ? 32'hDEAD_BEEF : mem[ridx];
          m_axil_rresp  = (rd_num == bad_r) ? 2'b10 : 2'b00;
          rd_num++;
          m_axil_rvalid = 1;
        end
        if (m_axil_rvalid && m_axil_rready) begin
          r_hs = 1; ar_got = 0; last_r_cyc = cyc;
        end
        m_axil_arready = 0;
        if (m_axil_arvalid) begin
          if (ar_got) dup_cnt++;
          else begin
            m_axil_arready = 1; ar_got = 1; ar_a = m_axil_araddr;
            chk("arprot", {29'h0, m_axil_arprot}, 32'h0);
            if (exp_rd.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_read: addr %h, none expected", m_axil_araddr);
            end else chk("rd_addr", {28'h0, m_axil_araddr}, {28'h0, exp_rd.pop_front()});
          end
        end
      end
    end
  end

  // Done monitor: pops the expected pass result whenever the DUT pulses done.
  initial begin
    logic prev_done;
    res_t r;
    prev_done = 0;
    forever begin
      @(negedge aclk);
      #2;
      if (done) begin
        chk("done_one_cycle", {31'h0, prev_done}, 32'h0);
        if (exp_res.size() == 0) chk("done_unexpected", {31'h0, done}, 32'h0);
        else begin
          r = exp_res.pop_front();
          chk("done_err", {31'h0, err}, {31'h0, r.e});
          chk("done_err_idx", {30'h0, err_idx}, {30'h0, r.idx});
          chk("done_busy", {31'h0, busy}, 32'h0);
          chk("done_latency", cyc, (RB ? last_r_cyc : last_b_cyc) + 1);
        end
      end
      prev_done = done;
    end
  end

  task automatic run_pass(input logic [31:0] pat, input logic e, input logic [1:0] ei,
                          input bit poke, input string tag);
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back('{addr: 4'(i * 4), data: pat + 32'(i)});
      if (RB) exp_rd.push_back(4'(i * 4));
    end
    exp_res.push_back('{e: e, idx: ei});
    wr_num = 0; rd_num = 0; dup_cnt = 0;
    @(negedge aclk);
    start = 1; pattern = pat;
    @(negedge aclk);
    start = 0; pattern = 32'h0;
    chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
    for (int t = 0; t < 300 && exp_res.size() != 0; t++) begin
      @(negedge aclk);
      if (poke && t == 5) begin start = 1; pattern = 32'h5555_5555; end
      if (poke && t == 6) begin start = 0; pattern = 32'h0; end
    end
    start = 0;
    chk({tag, "_timeout"}, exp_res.size(), 0);
    exp_res.delete();
    @(negedge aclk);
    chk({tag, "_writes_left"}, exp_wr.size(), 0);
    chk({tag, "_reads_left"}, exp_rd.size(), 0);
    chk({tag, "_dup_valid"}, dup_cnt, 0);
    chk({tag, "_write_count"}, wr_num, 4);
    exp_wr.delete(); exp_rd.delete();
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] r3);
    chk({tag, "_reg0"}, mem[0], r0);
    chk({tag, "_reg1"}, mem[1], r1);
    chk({tag, "_reg2"}, mem[2], r2);
    chk({tag, "_reg3"}, mem[3], r3);
  endtask

  initial begin
    areset = 1; start = 0; pattern = 0;
    aw_delay = 0; w_delay = 0; bad_b = -1; bad_r = -1; corrupt_reg = -1;
    repeat (3) @(negedge aclk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_valids", {28'h0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready}, 32'h0);
    areset = 0;

    run_pass(32'h1000_0000, 1'b0, 2'd0, 1'b0, "t1");
    chk_mem("t1", 32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003);

    corrupt_reg = 2;
    run_pass(32'h1000_0000, RB, RB ? 2'd2 : 2'd0, 1'b0, "t2");
    corrupt_reg = -1;

    bad_b = 1; bad_r = 3;
    run_pass(32'h0000_0100, 1'b1, 2'd1, 1'b0, "t3");
    chk_mem("t3", 32'h0000_0100, 32'h0000_0101, 32'h0000_0102, 32'h0000_0103);
    bad_b = -1; bad_r = -1;

    aw_delay = 3; w_delay = 0;
    run_pass(32'hA5A5_0000, 1'b0, 2'd0, 1'b1, "t4a");
    chk_mem("t4a", 32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003);
    aw_delay = 0; w_delay = 3;
    run_pass(32'h0000_7FFE, 1'b0, 2'd0, 1'b0, "t4b");
    chk_mem("t4b", 32'h0000_7FFE, 32'h0000_7FFF, 32'h0000_8000, 32'h0000_8001);

    // Reset while the second write is still waiting for awready.
    aw_delay = 3; w_delay = 0; bad_b = 0; wr_num = 0;
    exp_wr.push_back('{addr: 4'h0, data: 32'h2000_0000});
    @(negedge aclk);
    start = 1; pattern = 32'h2000_0000;
    @(negedge aclk);
    start = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge aclk);
      if (m_axil_awvalid && wr_num == 1) break;
    end
    chk("t5_mid_awvalid", {31'h0, m_axil_awvalid}, 32'h1);
    chk("t5_mid_err", {31'h0, err}, 32'h1);
    areset = 1;
    exp_wr.delete();
    @(negedge aclk);
    chk("t5_valids", {27'h0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready,
                      m_axil_rready}, 32'h0);
    chk("t5_busy_done", {30'h0, busy, done}, 32'h0);
    chk("t5_err", {29'h0, err, err_idx}, 32'h0);
    chk("t5_awaddr", {28'h0, m_axil_awaddr}, 32'h0);
    chk("t5_wdata", m_axil_wdata, 32'h0);
    areset = 0; aw_delay = 0; bad_b = -1;

    // start coinciding with reset must be dropped.
    @(negedge aclk);
    areset = 1; start = 1; pattern = 32'h1234_5678;
    @(negedge aclk);
    areset = 0; start = 0; pattern = 0;
    repeat (3) @(negedge aclk);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_awvalid", {31'h0, m_axil_awvalid}, 32'h0);

    run_pass(32'hFFFF_FFFF, 1'b0, 2'd0, 1'b0, "t7");
    chk_mem("t7", 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002);

    repeat (2) @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
